// File: rtl/config_stream_loader_pkg.sv
// Shared types for the configuration stream loader: message/error/state enums
// and the header field layout of the first beat of every packet.
package cfg_loader_pkg;

    typedef enum logic [3:0] {
        WEIGHTS    = 4'd0,
        THRESHOLDS = 4'd1
    } msg_type_e;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        BAD_HDR = 2'd1,
        SHORT   = 2'd2,
        LONG    = 2'd3
    } err_code_e;

    typedef enum logic [1:0] {
        HDR     = 2'd0,
        PAYLOAD = 2'd1,
        DRAIN   = 2'd2
    } state_e;

    localparam int HDR_TYPE_LSB  = 0;
    localparam int HDR_TYPE_W    = 4;
    localparam int HDR_LAYER_LSB = 4;
    localparam int HDR_LAYER_W   = 8;
    localparam int HDR_LEN_LSB   = 16;
    localparam int HDR_LEN_W     = 16;

    // A header is unusable when its type is unknown or it targets a missing layer.
    function automatic logic hdr_is_bad(input logic [HDR_TYPE_W-1:0]  msg_type,
                                        input logic [HDR_LAYER_W-1:0] layer,
                                        input int                     layers);
        return (msg_type > THRESHOLDS) || (int'(layer) >= layers);
    endfunction

endpackage

// File: rtl/config_stream_loader_if.sv
// Configuration stream: valid/ready beats with byte keep and end-of-packet marker.
interface config_stream_if #(
    parameter int CONFIG_BUS_WIDTH = 32
);
    logic [CONFIG_BUS_WIDTH-1:0]   config_data_in;
    logic                          config_valid;
    logic [CONFIG_BUS_WIDTH/8-1:0] config_keep;
    logic                          config_last;
    logic                          config_ready;

    modport master (
        output config_data_in, config_valid, config_keep, config_last,
        input  config_ready
    );

    modport slave (
        input  config_data_in, config_valid, config_keep, config_last,
        output config_ready
    );
endinterface

// File: rtl/config_stream_loader_packer.sv
// Packs narrow stream beats (first beat lowest) into one wide write word,
// zeroing unkept bytes and closing the word early on flush.
module cfg_word_packer #(
    parameter int CONFIG_BUS_WIDTH = 32,
    parameter int BUS_WIDTH        = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          beat_valid,
    input  logic [CONFIG_BUS_WIDTH-1:0]   beat_data,
    input  logic [CONFIG_BUS_WIDTH/8-1:0] beat_keep,
    input  logic                          flush,
    output logic [BUS_WIDTH-1:0]          word,
    output logic                          word_valid
);
    localparam int RATIO = BUS_WIDTH / CONFIG_BUS_WIDTH;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [CNT_W-1:0]            beat_cnt_q;
    logic [BUS_WIDTH-1:0]        acc_q;
    logic [CONFIG_BUS_WIDTH-1:0] masked;

    always_comb begin
        masked = '0;
        for (int b = 0; b < CONFIG_BUS_WIDTH/8; b++) begin
            if (beat_keep[b]) masked[8*b +: 8] = beat_data[8*b +: 8];
        end
    end

    // Slots above the current beat are still zero in acc_q, so an early flush
    // naturally leaves the missing upper beats cleared.
    always_comb begin
        word = acc_q;
        for (int i = 0; i < RATIO; i++) begin
            if (beat_cnt_q == CNT_W'(i)) word[i*CONFIG_BUS_WIDTH +: CONFIG_BUS_WIDTH] = masked;
        end
    end

    assign word_valid = beat_valid && (flush || (beat_cnt_q == CNT_W'(RATIO-1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
            acc_q      <= '0;
        end else if (beat_valid) begin
            if (word_valid) begin
                beat_cnt_q <= '0;
                acc_q      <= '0;
            end else begin
                beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                acc_q      <= word;
            end
        end
    end

endmodule

// File: rtl/config_stream_loader.sv
// Config stream loader: parses header + payload packets from the stream and
// issues packed, addressed writes to per-layer weight/threshold memories.
module config_stream_loader
    import cfg_loader_pkg::*;
#(
    parameter int CONFIG_BUS_WIDTH = 32,
    parameter int BUS_WIDTH        = 64,
    parameter int LAYERS           = 3,
    parameter int ADDR_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    config_stream_if.slave        cfg_s,
    output logic [BUS_WIDTH-1:0]  wr_data,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [LAYERS-1:0]     weight_wr_en,
    output logic [LAYERS-1:0]     threshold_wr_en,
    output logic                  cfg_done,
    output logic                  cfg_error,
    output logic [1:0]            err_code,
    input  logic                  err_clear,
    output logic [2*LAYERS-1:0]   layers_loaded
);

    state_e                   state_q, state_d;
    logic                     ready_q;
    logic                     beat_acc, beat_last;
    logic [HDR_TYPE_W-1:0]    hdr_type;
    logic [HDR_LAYER_W-1:0]   hdr_layer;
    logic [HDR_LEN_W-1:0]     hdr_len;
    logic                     hdr_bad, hdr_len_zero;
    logic                     is_thr_q;
    logic [HDR_LAYER_W-1:0]   layer_q;
    logic [HDR_LEN_W-1:0]     len_q, word_cnt_q;
    logic                     last_word;
    logic                     pack_valid, word_valid;
    logic [BUS_WIDTH-1:0]     word;
    logic                     hdr_load, wr_go, done_go, loaded_go, err_go;
    err_code_e                err_new;
    logic [LAYERS-1:0]        layer_sel;
    logic [2*LAYERS-1:0]      loaded_set;

    assign cfg_s.config_ready = ready_q;
    assign beat_acc     = cfg_s.config_valid && ready_q;
    assign beat_last    = cfg_s.config_last;
    assign hdr_type     = cfg_s.config_data_in[HDR_TYPE_LSB  +: HDR_TYPE_W];
    assign hdr_layer    = cfg_s.config_data_in[HDR_LAYER_LSB +: HDR_LAYER_W];
    assign hdr_len      = cfg_s.config_data_in[HDR_LEN_LSB   +: HDR_LEN_W];
    assign hdr_bad      = hdr_is_bad(hdr_type, hdr_layer, LAYERS);
    assign hdr_len_zero = (hdr_len == '0);
    assign last_word    = (word_cnt_q == len_q - HDR_LEN_W'(1));
    assign pack_valid   = beat_acc && (state_q == PAYLOAD);

    cfg_word_packer #(
        .CONFIG_BUS_WIDTH (CONFIG_BUS_WIDTH),
        .BUS_WIDTH        (BUS_WIDTH)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .beat_valid (pack_valid),
        .beat_data  (cfg_s.config_data_in),
        .beat_keep  (cfg_s.config_keep),
        .flush      (beat_last),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= HDR;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (beat_acc) begin
            unique case (state_q)
                HDR: begin
                    if (hdr_bad)          state_d = beat_last ? HDR : DRAIN;
                    else if (!beat_last)  state_d = hdr_len_zero ? DRAIN : PAYLOAD;
                end
                PAYLOAD: begin
                    if (word_valid) begin
                        if (last_word && !beat_last) state_d = DRAIN;
                        else if (beat_last)          state_d = HDR;
                    end
                end
                DRAIN: begin
                    if (beat_last) state_d = HDR;
                end
                default: state_d = HDR;
            endcase
        end
    end

    // Per-beat actions; everything they drive is registered one cycle later.
    always_comb begin
        hdr_load  = 1'b0;
        wr_go     = 1'b0;
        done_go   = 1'b0;
        loaded_go = 1'b0;
        err_go    = 1'b0;
        err_new   = NONE;
        if (beat_acc) begin
            case (state_q)
                HDR: begin
                    if (hdr_bad) begin
                        err_go  = 1'b1;
                        err_new = BAD_HDR;
                    end else if (hdr_len_zero) begin
                        if (beat_last) begin
                            done_go = 1'b1;
                        end else begin
                            err_go  = 1'b1;
                            err_new = LONG;
                        end
                    end else if (beat_last) begin
                        err_go  = 1'b1;
                        err_new = SHORT;
                    end else begin
                        hdr_load = 1'b1;
                    end
                end
                PAYLOAD: begin
                    if (word_valid) begin
                        wr_go = 1'b1;
                        if (last_word) begin
                            if (beat_last) begin
                                done_go   = 1'b1;
                                loaded_go = 1'b1;
                            end else begin
                                err_go  = 1'b1;
                                err_new = LONG;
                            end
                        end else if (beat_last) begin
                            err_go  = 1'b1;
                            err_new = SHORT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int l = 0; l < LAYERS; l++) begin
            layer_sel[l]      = (int'(layer_q) == l);
            loaded_set[2*l]   = loaded_go && !is_thr_q && layer_sel[l];
            loaded_set[2*l+1] = loaded_go &&  is_thr_q && layer_sel[l];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q         <= 1'b0;
            is_thr_q        <= 1'b0;
            layer_q         <= '0;
            len_q           <= '0;
            word_cnt_q      <= '0;
            wr_data         <= '0;
            wr_addr         <= '0;
            weight_wr_en    <= '0;
            threshold_wr_en <= '0;
            cfg_done        <= 1'b0;
            cfg_error       <= 1'b0;
            err_code        <= NONE;
            layers_loaded   <= '0;
        end else begin
            ready_q <= 1'b1;

            if (hdr_load) begin
                is_thr_q   <= hdr_type[0];
                layer_q    <= hdr_layer;
                len_q      <= hdr_len;
                word_cnt_q <= '0;
            end else if (wr_go) begin
                word_cnt_q <= word_cnt_q + HDR_LEN_W'(1);
            end

            weight_wr_en    <= '0;
            threshold_wr_en <= '0;
            if (wr_go) begin
                wr_data         <= word;
                wr_addr         <= ADDR_WIDTH'(word_cnt_q);
                weight_wr_en    <= is_thr_q ? '0 : layer_sel;
                threshold_wr_en <= is_thr_q ? layer_sel : '0;
            end

            cfg_done      <= done_go;
            layers_loaded <= layers_loaded | loaded_set;

            // A new error beats a simultaneous clear and restarts the first-error record.
            if (err_go) begin
                cfg_error <= 1'b1;
                if (!cfg_error || err_clear) err_code <= err_new;
            end else if (err_clear) begin
                cfg_error <= 1'b0;
                err_code  <= NONE;
            end
        end
    end

endmodule

// File: tb/tb_config_stream_loader.sv
// Scoreboard bench for config_stream_loader: a packet-level reference model
// predicts writes and status; a monitor checks every strobe the DUT produces.
module tb_config_stream_loader;

    localparam int CW    = 32;
    localparam int BW    = 64;
    localparam int NL    = 3;
    localparam int AW    = 16;
    localparam int RATIO = BW / CW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_clear = 1'b0;
    always #5 clk = ~clk;

    config_stream_if #(.CONFIG_BUS_WIDTH(CW)) cfg_if();

    logic [BW-1:0]   wr_data;
    logic [AW-1:0]   wr_addr;
    logic [NL-1:0]   weight_wr_en, threshold_wr_en;
    logic            cfg_done, cfg_error;
    logic [1:0]      err_code;
    logic [2*NL-1:0] layers_loaded;

    config_stream_loader #(
        .CONFIG_BUS_WIDTH (CW),
        .BUS_WIDTH        (BW),
        .LAYERS           (NL),
        .ADDR_WIDTH       (AW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_s           (cfg_if),
        .wr_data         (wr_data),
        .wr_addr         (wr_addr),
        .weight_wr_en    (weight_wr_en),
        .threshold_wr_en (threshold_wr_en),
        .cfg_done        (cfg_done),
        .cfg_error       (cfg_error),
        .err_code        (err_code),
        .err_clear       (err_clear),
        .layers_loaded   (layers_loaded)
    );

    typedef struct {
        logic [NL-1:0] wen;
        logic [NL-1:0] ten;
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
        logic          done;
    } exp_t;

    exp_t            exp_q[$];
    exp_t            mon_e;
    int              checks = 0;
    int              errors = 0;
    logic            m_err = 1'b0;
    logic [1:0]      m_code = 2'd0;
    logic [2*NL-1:0] m_loaded = '0;
    logic [BW-1:0]   last_data = '0;
    logic [AW-1:0]   last_addr = '0;
    logic [NL-1:0]   last_wen = '0, last_ten = '0;
    logic [CW-1:0]   pd [0:15];
    logic [CW/8-1:0] pk [0:15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (packet level) ----------------
    function automatic logic [CW-1:0] mask_beat(input logic [CW-1:0] d, input logic [CW/8-1:0] k);
        logic [CW-1:0] r;
        r = '0;
        for (int b = 0; b < CW/8; b++) if (k[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic model_raise(input logic [1:0] code);
        if (!m_err) m_code = code;
        m_err = 1'b1;
    endtask

    task automatic model_packet(input int typ, input int layer, input int n, input int nb, input logic clr);
        exp_t e;
        int   avail, nw, idx;
        if (clr) begin m_err = 1'b0; m_code = 2'd0; end
        if (typ > 1 || layer >= NL) begin
            model_raise(2'd1);
        end else if (nb == 0) begin
            if (n == 0) begin
                e.wen = '0; e.ten = '0; e.addr = '0; e.data = '0; e.done = 1'b1;
                exp_q.push_back(e);
            end else begin
                model_raise(2'd2);
            end
        end else if (n == 0) begin
            model_raise(2'd3);
        end else begin
            avail = (nb + RATIO - 1) / RATIO;
            nw    = (avail < n) ? avail : n;
            for (int w = 0; w < nw; w++) begin
                e.data = '0;
                for (int s = 0; s < RATIO; s++) begin
                    idx = w*RATIO + s;
                    if (idx < nb) e.data[s*CW +: CW] = mask_beat(pd[idx], pk[idx]);
                end
                e.wen  = (typ == 0) ? NL'(1 << layer) : '0;
                e.ten  = (typ == 1) ? NL'(1 << layer) : '0;
                e.addr = AW'(w);
                e.done = (w == n-1) && (avail == n);
                exp_q.push_back(e);
            end
            if (avail == n)     m_loaded[2*layer + typ] = 1'b1;
            else if (avail > n) model_raise(2'd3);
            else                model_raise(2'd2);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && (weight_wr_en != '0 || threshold_wr_en != '0 || cfg_done)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: wen=%b ten=%b done=%b addr=%0d data=0x%0h, nothing expected",
                         weight_wr_en, threshold_wr_en, cfg_done, wr_addr, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (weight_wr_en !== mon_e.wen || threshold_wr_en !== mon_e.ten || cfg_done !== mon_e.done ||
                    ((mon_e.wen | mon_e.ten) != '0 && (wr_addr !== mon_e.addr || wr_data !== mon_e.data))) begin
                    errors++;
                    $display("FAIL write_compare: got wen=%b ten=%b done=%b addr=%0d data=0x%0h, expected wen=%b ten=%b done=%b addr=%0d data=0x%0h",
                             weight_wr_en, threshold_wr_en, cfg_done, wr_addr, wr_data,
                             mon_e.wen, mon_e.ten, mon_e.done, mon_e.addr, mon_e.data);
                end
            end
            if (weight_wr_en != '0 || threshold_wr_en != '0) begin
                last_data = wr_data;
                last_addr = wr_addr;
                last_wen  = weight_wr_en;
                last_ten  = threshold_wr_en;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_beat(input logic [CW-1:0] d, input logic [CW/8-1:0] k, input logic l,
                              input logic clr, input bit gaps);
        int t;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        cfg_if.config_data_in = d;
        cfg_if.config_keep    = k;
        cfg_if.config_last    = l;
        cfg_if.config_valid   = 1'b1;
        err_clear             = clr;
        t = 0;
        while (cfg_if.config_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("ready_at_beat", 64'(cfg_if.config_ready), 64'(1'b1));
        @(negedge clk);
        cfg_if.config_valid = 1'b0;
        cfg_if.config_last  = 1'b0;
        err_clear           = 1'b0;
    endtask

    function automatic logic [CW-1:0] make_hdr(input int typ, input int layer, input int n);
        logic [CW-1:0] h;
        h        = '0;
        h[3:0]   = 4'(typ);
        h[11:4]  = 8'(layer);
        h[15:12] = 4'($urandom);
        h[31:16] = 16'(n);
        return h;
    endfunction

    task automatic send_packet(input int typ, input int layer, input int n, input int nb,
                               input logic clr, input bit gaps);
        model_packet(typ, layer, n, nb, clr);
        drive_beat(make_hdr(typ, layer, n), 4'hF, nb == 0, clr, gaps);
        for (int i = 0; i < nb; i++) drive_beat(pd[i], pk[i], i == nb-1, 1'b0, gaps);
        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        check("cfg_error", 64'(cfg_error), 64'(m_err));
        check("err_code", 64'(err_code), 64'(m_code));
        check("layers_loaded", 64'(layers_loaded), 64'(m_loaded));
    endtask

    task automatic clear_errors();
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        m_err = 1'b0;
        m_code = 2'd0;
        check("cfg_error_after_clear", 64'(cfg_error), 64'(1'b0));
        check("err_code_after_clear", 64'(err_code), 64'(2'd0));
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) begin
            pd[i] = $urandom;
            pk[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cfg_if.config_data_in = '0;
        cfg_if.config_keep    = '0;
        cfg_if.config_last    = 1'b0;
        cfg_if.config_valid   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ready", 64'(cfg_if.config_ready), 64'(1'b0));
        check("reset_en", 64'({weight_wr_en, threshold_wr_en}), 64'(0));
        check("reset_status", 64'({cfg_done, cfg_error, err_code}), 64'(0));
        check("reset_loaded", 64'(layers_loaded), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("ready_after_reset", 64'(cfg_if.config_ready), 64'(1'b1));

        // Weights, layer 1, two words from four beats.
        pd[0] = 32'hA0A1A2A3; pd[1] = 32'hB0B1B2B3; pd[2] = 32'hC0C1C2C3; pd[3] = 32'hD0D1D2D3;
        for (int i = 0; i < 4; i++) pk[i] = 4'hF;
        send_packet(0, 1, 2, 4, 1'b0, 1'b0);
        check("t1_loaded", 64'(layers_loaded), 64'(6'b000100));
        check("t1_last_data", last_data, 64'hD0D1D2D3_C0C1C2C3);
        check("t1_last_addr", 64'(last_addr), 64'(1));
        check("t1_last_wen", 64'(last_wen), 64'(3'b010));

        // Thresholds, layer 2, one partial-keep beat.
        pd[0] = 32'h11223344; pk[0] = 4'b0011;
        send_packet(1, 2, 1, 1, 1'b0, 1'b1);
        check("t2_data", last_data, 64'h0000_0000_0000_3344);
        check("t2_ten", 64'(last_ten), 64'(3'b100));

        // Bad layer, drained.
        fill_random();
        send_packet(0, 5, 2, 3, 1'b0, 1'b1);
        check("t3_err_code", 64'(err_code), 64'(2'd1));
        clear_errors();

        // Short packet: N=3, last on beat 4.
        fill_random();
        send_packet(0, 0, 3, 4, 1'b0, 1'b1);
        check("t4_err_code", 64'(err_code), 64'(2'd2));
        clear_errors();

        // Long packet: N=1 with four beats, then a good header.
        fill_random();
        send_packet(1, 0, 1, 4, 1'b0, 1'b1);
        check("t5_err_code", 64'(err_code), 64'(2'd3));
        fill_random();
        send_packet(0, 2, 1, 2, 1'b0, 1'b0);

        // Error raised in the same cycle as a clear wins.
        send_packet(2, 0, 1, 0, 1'b1, 1'b0);
        check("t6_err_code", 64'(err_code), 64'(2'd1));

        // Empty valid packet, empty packet with trailing beats, reload of a layer.
        send_packet(1, 1, 0, 0, 1'b0, 1'b0);
        fill_random();
        send_packet(0, 0, 0, 2, 1'b0, 1'b0);
        fill_random();
        send_packet(0, 1, 1, 2, 1'b0, 1'b1);

        // Reset mid-packet, after one payload beat.
        fill_random();
        drive_beat(make_hdr(0, 0, 2), 4'hF, 1'b0, 1'b0, 1'b0);
        drive_beat(pd[0], 4'hF, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", 64'(cfg_if.config_ready), 64'(1'b0));
        check("rst_wr", 64'(wr_data | 64'(wr_addr)), 64'(0));
        check("rst_en", 64'({weight_wr_en, threshold_wr_en}), 64'(0));
        check("rst_status", 64'({cfg_done, cfg_error, err_code}), 64'(0));
        check("rst_loaded", 64'(layers_loaded), 64'(0));
        m_err = 1'b0; m_code = 2'd0; m_loaded = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        fill_random();
        send_packet(0, 0, 1, 2, 1'b0, 1'b0);
        check("post_reset_addr", 64'(last_addr), 64'(0));

        // Randomized packets.
        for (int p = 0; p < 40; p++) begin
            int   typ, lay, n, nb;
            logic clr;
            typ = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 15)) : int'($urandom_range(0, 1));
            lay = ($urandom_range(0, 9) == 0) ? int'($urandom_range(NL, 255)) : int'($urandom_range(0, NL-1));
            n   = $urandom_range(0, 4);
            if ($urandom_range(0, 9) < 6) nb = (n == 0) ? 0 : n*RATIO - int'($urandom_range(0, 1));
            else                          nb = $urandom_range(0, 9);
            clr = ($urandom_range(0, 7) == 0);
            fill_random();
            if ($urandom_range(0, 7) == 0) clear_errors();
            send_packet(typ, lay, n, nb, clr, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/config_stream_loader.md
CONFIG_STREAM_LOADER -- requirements
Module: config_stream_loader

Interface
REQ-001 The block SHALL have parameter CONFIG_BUS_WIDTH, default 32: input stream data width in bits; must be ≥32 and a multiple of 8.
REQ-002 The block SHALL have parameter BUS_WIDTH, default 64: output write-data width; must be an integer multiple of CONFIG_BUS_WIDTH.
REQ-003 The block SHALL have parameter LAYERS, default 3: number of layers (1..256).
REQ-004 The block SHALL have parameter ADDR_WIDTH, default 16: width of the write address.
REQ-005 The block SHALL have the port clk, input, 1: the single clock.
REQ-006 The block SHALL have the port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 The block SHALL have the ports config_data_in, input, CONFIG_BUS_WIDTH; config_valid, input, 1; config_keep, input, CONFIG_BUS_WIDTH/8; config_last, input, 1; config_ready, output, 1. Together these form the stream slave.
REQ-008 The block SHALL have the ports wr_data, output, BUS_WIDTH; wr_addr, output, ADDR_WIDTH. These are shared by all write enables.
REQ-009 The block SHALL have the ports weight_wr_en, output, LAYERS; threshold_wr_en, output, LAYERS. These are one-hot-or-zero write strobes.
REQ-010 The block SHALL have the ports cfg_done, output, 1: a one-cycle pulse when a packet completes without error.
REQ-011 The block SHALL have the ports cfg_error, output, 1 (sticky); err_code, output, 2; err_clear, input, 1.
REQ-012 The block SHALL have the port layers_loaded, output, 2*LAYERS. Bit 2*L is "weights loaded" for layer L; bit 2*L+1 is "thresholds loaded" for layer L.

Function
REQ-013 A beat SHALL be accepted when config_valid && config_ready are both high; config_ready SHALL be 1 at all times except during reset.
REQ-014 The first accepted beat of each packet SHALL be its header: bits[3:0] type (0 = weights, 1 = thresholds), bits[11:4] layer, bits[31:16] N, the payload length in BUS_WIDTH words.
REQ-015 The block SHALL have the states HDR, PAYLOAD and DRAIN; the reset state is HDR.
REQ-016 The transitions out of HDR on a header beat SHALL be:
- a valid header with N > 0 and config_last = 0 -> PAYLOAD;
- a valid header with N = 0 and config_last = 1 -> cfg_done, stay in HDR;
- a type > 1 or a layer ≥ LAYERS -> error BAD_HDR (code 1), then DRAIN, or stay in HDR if config_last = 1;
- N > 0 with config_last = 1 -> error SHORT (code 2), stay in HDR;
- N = 0 with config_last = 0 -> error LONG (code 3), then DRAIN.
REQ-017 In PAYLOAD, the block SHALL pack BUS_WIDTH/CONFIG_BUS_WIDTH beats into one output word, with the first beat in the least-significant position.
REQ-018 Bytes whose config_keep bit is 0 SHALL be written as zero.
REQ-019 A word SHALL also complete early on config_last; the missing upper beats SHALL then be zero.
REQ-020 On each completed word, the block SHALL register wr_data and wr_addr and assert exactly one enable bit, selected by type and layer, in the cycle after the completing beat (latency 1).
REQ-021 wr_addr SHALL start at 0 for each packet and increment by 1 per written word.
REQ-022 The PAYLOAD exit conditions SHALL be:
- word N completes together with config_last -> cfg_done pulse in the same cycle as the last enable, set the matching layers_loaded bit, go to HDR;
- word N completes without config_last -> write the word, raise LONG, go to DRAIN;
- config_last before word N -> write the partial word, raise SHORT, go to HDR, set no loaded bit.
REQ-023 DRAIN SHALL accept and discard beats until config_last, then go to HDR; it SHALL assert no write enables.
REQ-024 cfg_error SHALL set on any error and hold.
REQ-025 err_code SHALL hold the first error raised since the last clear.
REQ-026 err_clear SHALL clear cfg_error and err_code the next cycle. An error raised in the same cycle as err_clear SHALL take priority.
REQ-027 Reloading a layer that is already loaded SHALL be legal: it overwrites the data and keeps the loaded bit set.
REQ-028 config_valid held low mid-packet SHALL stall packing with no state change.

Reset
REQ-029 While rst_n = 0, the block SHALL asynchronously force the state to HDR and the beat counter and word counter to 0.
REQ-030 While rst_n = 0, the block SHALL force the outputs to: config_ready 0; wr_data 0; wr_addr 0; all enables 0; cfg_done 0; cfg_error 0; err_code 0; layers_loaded 0.
REQ-031 A reset asserted mid-packet SHALL discard the partial word. The first beat accepted after reset SHALL be treated as a header.

Structure
REQ-032 A shared package cfg_loader_pkg SHALL hold:
- the message type enum (WEIGHTS = 0, THRESHOLDS = 1);
- the error code enum (NONE, BAD_HDR, SHORT, LONG);
- the header field bit positions;
- the state enum.
REQ-033 Packing SHALL live in one sub-module, cfg_word_packer. Its ports are beat in, keep, last-flush, word out and word_valid.

Verification
REQ-034 The bench SHALL cover a weights header for layer 1 with N = 2, then beats A, B, C, D with last on D -> weight_wr_en = 3'b010 at addr 0 with {B,A} and at addr 1 with {D,C}, cfg_done once, layers_loaded = 6'b000100.
REQ-035 The bench SHALL cover a thresholds header for layer 2 with N = 1, then one beat 0x11223344 with keep = 4'b0011 and last -> threshold_wr_en = 3'b100 with data 0x0000_0000_0000_3344.
REQ-036 The bench SHALL cover a header with layer = 5, followed by 3 beats, last on the third -> no enables, cfg_error = 1, err_code = 1, ready high throughout.
REQ-037 The bench SHALL cover a header with N = 3 and last on beat 4 -> two writes, err_code = 2, no loaded bit; then err_clear -> cfg_error = 0 next cycle.
REQ-038 The bench SHALL cover a header with N = 1, followed by 4 beats -> one write, err_code = 3, the remaining beats drained, the next header parsed correctly.
REQ-039 The bench SHALL cover rst_n pulsed low after one payload beat -> all outputs 0 immediately; a fresh packet after release loads correctly at addr 0.
